jk_triple_checker: RTL
======================

# jk_triple_checker

Self-checking monitor that sits directly downstream of the three-way JK flip-flop block (SR-, D- and T-based implementations). It observes the same J/K stimulus driven into that block, runs an internal golden JK register, and compares all three Q outputs against it every cycle. It reports per-implementation mismatch flags, a saturating error count, and a snapshot of the first failure. A small FSM sequences it through arm, check and fail phases.

## Interface
- CNT_W, 16, width of cycle counter and first-error timestamp
- ERR_W, 8, width of saturating mismatch counter

- clk  in  1  clock; the JK block under check uses the same clock and the same posedge
- reset  in  1  asynchronous, active-low; clears all state
- en  in  1  run checking; level-sensitive
- clr  in  1  synchronous clear of counters, status and FSM
- J, K  in  1  same J/K nets that drive the JK block
- Q_sr, Q_d, Q_t  in  1  outputs of the three JK implementations
- q_ref  out  1  golden JK model output
- mismatch  out  3  registered per-cycle mismatch: [2] SR, [1] D, [0] T
- err_cnt  out  ERR_W  count of cycles with any mismatch; saturates at all-ones
- first_err_cyc  out  CNT_W  cycle index of the first counted mismatch
- first_err_vec  out  3  mismatch vector of that first failure
- sticky_err  out  1  set on first counted mismatch; held until clr or reset
- state  out  2  FSM state: IDLE=0, ARM=1, CHECK=2, FAIL=3

## Operation
- Golden model: q_ref <= (J & ~q_ref) | (~K & q_ref) on every posedge, independent of en and state. This gives hold, reset, set and toggle behaviour.
- Raw compare: mm_raw = {Q_sr^q_ref, Q_d^q_ref, Q_t^q_ref}. mismatch <= mm_raw on every posedge, regardless of state.
- FSM:
  - IDLE: when en=1, go to ARM.
  - ARM: lasts one cycle; cyc_cnt <= 0; go to CHECK.
  - CHECK: if |mm_raw, go to FAIL; if en=0, go to IDLE.
  - FAIL: stays until clr or reset; en has no effect.
- Counting: in CHECK and FAIL, cyc_cnt increments each posedge and saturates at all-ones. err_cnt increments when |mm_raw and saturates.
- First failure: on the CHECK-to-FAIL edge, first_err_cyc <= cyc_cnt, first_err_vec <= mm_raw, and sticky_err <= 1.
- Mismatches seen in IDLE or ARM are reflected on mismatch but are not counted.
- clr: state goes to IDLE; err_cnt, cyc_cnt, first_err_* and sticky_err go to 0. q_ref and mismatch are unaffected.
- clr takes priority over a simultaneous mismatch or en.

## Timing
- Reset values: q_ref=0, mismatch=0, err_cnt=0, first_err_cyc=0, first_err_vec=0, sticky_err=0, state=IDLE. The JK block also resets all its Q outputs to 0, so the two stay aligned out of reset.
- Divergence latency: a divergence created at posedge e appears on mismatch, err_cnt and the FSM at posedge e+1.
- Check window: en rising before edge n means ARM during cycle n and CHECK from edge n+1. The first CHECK cycle has cyc_cnt=0.
- Reset asserted mid-check returns everything to reset values immediately (asynchronous). Deassertion is synchronous to clk at the module boundary.
- Saturation: err_cnt and cyc_cnt hold at all-ones and never wrap.

## Configuration
- JK_CHK_HALT_EN:
  - Defined: in FAIL, cyc_cnt and err_cnt freeze at their values from the transition edge, so err_cnt=1 after a failure.
  - Undefined: both keep counting in FAIL, so err_cnt reflects the total number of mismatching cycles.

## Structure
- Package jk_chk_pkg holds:
  - the state enum (IDLE, ARM, CHECK, FAIL)
  - mismatch bit-index constants (MM_SR=2, MM_D=1, MM_T=0)
  - JK next-state function jk_next(j, k, q)
- Sub-module jk_ref_model: the golden register plus compare logic, producing q_ref and mm_raw.
- The FSM, counters and snapshot registers live in the top module.

## Test plan
- Reset then en=1 with a correct JK block; drive J/K over (0,0), (1,0), (0,1), (1,1) repeatedly for 20 cycles -> state=CHECK, err_cnt=0, sticky_err=0, q_ref tracks Q_sr.
- Force Q_d stuck-at-0 at CHECK cycle 5 while q_ref=1 -> mismatch=3'b010 one cycle later, state=FAIL, first_err_cyc=5, first_err_vec=3'b010, sticky_err=1.
- Continue the fault for 300 cycles with ERR_W=8 and the macro undefined -> err_cnt saturates at 255. With JK_CHK_HALT_EN defined -> err_cnt stays 1.
- Mismatch injected while en=0 (IDLE) -> mismatch flags go high, err_cnt=0, state stays IDLE.
- clr asserted in the same cycle as a new mismatch in CHECK -> state=IDLE, err_cnt=0, sticky_err=0.
- reset pulsed low mid-FAIL -> all outputs return to 0 and state=IDLE without waiting for a clock edge.

Source files
------------

// File: rtl/jk_chk_pkg.sv
// Shared types and helpers for the JK triple checker.
// Holds the FSM state encoding, mismatch bit positions and the JK next-state rule.
package jk_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_e;

    localparam int MM_SR = 2;
    localparam int MM_D  = 1;
    localparam int MM_T  = 0;

    function automatic logic jk_next(
        input logic j,
        input logic k,
        input logic q
    );
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_triple_checker_ref.sv
// Golden JK register and raw compare against the three implementations.
// mm_raw is combinational: it reflects the Q inputs against the current q_ref.
module jk_ref_model
    import jk_chk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       J,
    input  logic       K,
    input  logic       Q_sr,
    input  logic       Q_d,
    input  logic       Q_t,
    output logic       q_ref,
    output logic [2:0] mm_raw
);

    logic q_ref_q;
    logic q_ref_d;

    // Golden next state, independent of enable and FSM state
    always_comb begin
        q_ref_d = jk_next(J, K, q_ref_q);
    end

    // Golden JK register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q_ref_q <= 1'b0;
        else        q_ref_q <= q_ref_d;
    end

    // Per-implementation divergence from the golden value
    always_comb begin
        mm_raw        = 3'b000;
        mm_raw[MM_SR] = Q_sr ^ q_ref_q;
        mm_raw[MM_D]  = Q_d ^ q_ref_q;
        mm_raw[MM_T]  = Q_t ^ q_ref_q;
    end

    assign q_ref = q_ref_q;

endmodule

// File: rtl/jk_triple_checker.sv
// Monitor comparing three JK implementations against a golden register.
// Build option JK_CHK_HALT_EN freezes the counters once FAIL is entered.
module jk_triple_checker
    import jk_chk_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             J,
    input  logic             K,
    input  logic             Q_sr,
    input  logic             Q_d,
    input  logic             Q_t,
    output logic             q_ref,
    output logic [2:0]       mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_cyc,
    output logic [2:0]       first_err_vec,
    output logic             sticky_err,
    output logic [1:0]       state
);

    logic [2:0]       mm_raw;
    logic             mm_any;
    logic             cnt_en;

    state_e           state_q, state_d;
    logic [2:0]       mismatch_q, mismatch_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] fcyc_q, fcyc_d;
    logic [2:0]       fvec_q, fvec_d;
    logic             sticky_q, sticky_d;

    jk_ref_model u_ref (
        .clk    (clk),
        .reset  (reset),
        .J      (J),
        .K      (K),
        .Q_sr   (Q_sr),
        .Q_d    (Q_d),
        .Q_t    (Q_t),
        .q_ref  (q_ref),
        .mm_raw (mm_raw)
    );

    assign mm_any = |mm_raw;

`ifdef JK_CHK_HALT_EN
    assign cnt_en = (state_q == CHECK);
`else
    assign cnt_en = (state_q == CHECK) || (state_q == FAIL);
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; clr overrides everything, a mismatch beats en=0
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (en) state_d = ARM;
                ARM:     state_d = CHECK;
                CHECK: begin
                    if (mm_any)   state_d = FAIL;
                    else if (!en) state_d = IDLE;
                end
                FAIL:    state_d = FAIL;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters, first-failure snapshot and registered mismatch
    always_comb begin
        mismatch_d = mm_raw;
        cyc_d      = cyc_q;
        err_d      = err_q;
        fcyc_d     = fcyc_q;
        fvec_d     = fvec_q;
        sticky_d   = sticky_q;
        if (clr) begin
            cyc_d    = '0;
            err_d    = '0;
            fcyc_d   = '0;
            fvec_d   = 3'b000;
            sticky_d = 1'b0;
        end else begin
            if (state_q == ARM) cyc_d = '0;
            if (cnt_en) begin
                if (cyc_q != {CNT_W{1'b1}})
                    cyc_d = cyc_q + CNT_W'(1);
                if (mm_any && (err_q != {ERR_W{1'b1}}))
                    err_d = err_q + ERR_W'(1);
            end
            if ((state_q == CHECK) && mm_any) begin
                fcyc_d   = cyc_q;
                fvec_d   = mm_raw;
                sticky_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch_q <= 3'b000;
            cyc_q      <= '0;
            err_q      <= '0;
            fcyc_q     <= '0;
            fvec_q     <= 3'b000;
            sticky_q   <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
            cyc_q      <= cyc_d;
            err_q      <= err_d;
            fcyc_q     <= fcyc_d;
            fvec_q     <= fvec_d;
            sticky_q   <= sticky_d;
        end
    end

    assign mismatch      = mismatch_q;
    assign err_cnt       = err_q;
    assign first_err_cyc = fcyc_q;
    assign first_err_vec = fvec_q;
    assign sticky_err    = sticky_q;
    assign state         = state_q;

endmodule
